// File: rtl/uart_io_bridge.sv
`default_nettype none
// ============================================================================
// Module : uart_io_bridge
// Brief  : Host UART bridge; framed RAM-write commands in, FIFO-buffered OI bytes out.
// Rev    : 1.0  initial release
// ============================================================================
module uart_io_bridge #(
    parameter int         CLKS_PER_BIT   = 5208,
    parameter int         ADDR_W         = 4,
    parameter int         FIFO_DEPTH     = 8,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 10*5208*4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rxd,
    output logic              uart_txd,
    input  logic [7:0]        out_data,
    input  logic              out_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_we,
    output logic              tx_busy,
    output logic              tx_overflow,
    output logic              rx_error,
    input  logic              err_clr
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT/2 - 1);
    localparam logic [TO_W-1:0]  TO_MAX    = TO_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3;
    localparam logic [1:0] P_SYNC  = 2'd0, P_ADDR   = 2'd1, P_DATA  = 2'd2;
    localparam logic [1:0] TX_IDLE = 2'd0, TX_START = 2'd1, TX_DATA = 2'd2, TX_STOP = 2'd3;

    logic             r_rx_meta, r_rx_sync, r_rx_prev;
    logic [1:0]       r_rx_state;
    logic [CNT_W-1:0] r_rx_cnt;
    logic [2:0]       r_rx_bit;
    logic [7:0]       r_rx_shift;
    logic             r_byte_valid, r_frame_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta    <= 1'b1;
            r_rx_sync    <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_rx_state   <= RX_IDLE;
            r_rx_cnt     <= '0;
            r_rx_bit     <= '0;
            r_rx_shift   <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_meta    <= uart_rxd;
            r_rx_sync    <= r_rx_meta;
            r_rx_prev    <= r_rx_sync;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (r_rx_prev && !r_rx_sync) begin
                        r_rx_state <= RX_START;
                        r_rx_cnt   <= '0;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == HALF_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= r_rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
                        r_rx_bit   <= r_rx_bit + 1'b1;
                        if (r_rx_bit == 3'd7)
                            r_rx_state <= RX_STOP;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: begin
                    if (r_rx_cnt == BIT_LAST) begin
                        r_rx_cnt     <= '0;
                        r_byte_valid <= r_rx_sync;
                        r_frame_err  <= !r_rx_sync;
                        r_rx_state   <= RX_IDLE;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    logic [1:0]        r_p_state;
    logic [ADDR_W-1:0] r_addr;
    logic [TO_W-1:0]   r_idle_cnt;
    logic              w_addr_bad, w_addr_err, w_timeout, w_rx_err_set;

    assign w_addr_bad   = (r_rx_shift >> ADDR_W) != 8'd0;
    assign w_addr_err   = r_byte_valid && (r_p_state == P_ADDR) && w_addr_bad;
    assign w_timeout    = !r_byte_valid && !r_frame_err && (r_p_state != P_SYNC)
                          && (r_idle_cnt == TO_MAX);
    assign w_rx_err_set = r_frame_err || w_addr_err || w_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_p_state  <= P_SYNC;
            r_addr     <= '0;
            r_idle_cnt <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_data   <= '0;
        end else begin
            mem_we <= 1'b0;
            if (r_byte_valid)
                r_idle_cnt <= '0;
            else if (r_idle_cnt != TO_MAX)
                r_idle_cnt <= r_idle_cnt + 1'b1;

            if (r_frame_err || w_timeout) begin
                r_p_state <= P_SYNC;
            end else if (r_byte_valid) begin
                case (r_p_state)
                    P_SYNC: if (r_rx_shift == SYNC_BYTE) r_p_state <= P_ADDR;
                    P_ADDR: begin
                        if (w_addr_bad) begin
                            r_p_state <= P_SYNC;
                        end else begin
                            r_addr    <= r_rx_shift[ADDR_W-1:0];
                            r_p_state <= P_DATA;
                        end
                    end
                    P_DATA: begin
                        mem_we    <= 1'b1;
                        mem_addr  <= r_addr;
                        mem_data  <= r_rx_shift;
                        r_p_state <= P_SYNC;
                    end
                    default: r_p_state <= P_SYNC;
                endcase
            end
        end
    end

    logic [7:0]       r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [1:0]       r_tx_state;
    logic [CNT_W-1:0] r_tx_cnt;
    logic [2:0]       r_tx_bit;
    logic [7:0]       r_tx_shift;
    logic             r_txd, r_tx_tail;
    logic             w_empty, w_full, w_pop, w_push, w_ovf_set, w_tx_last, w_tx_line;

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[PTR_W-2:0] == r_rd_ptr[PTR_W-2:0])
                       && (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]);
    assign w_tx_last = (r_tx_cnt == BIT_LAST);
    // Popping on the last stop cycle lets the next start bit follow with no idle gap.
    assign w_pop     = !w_empty && ((r_tx_state == TX_IDLE) || ((r_tx_state == TX_STOP) && w_tx_last));
    assign w_push    = out_we && (!w_full || w_pop);
    assign w_ovf_set = out_we && w_full && !w_pop;
    assign w_tx_line = (r_tx_state == TX_START) ? 1'b0 :
                       (r_tx_state == TX_DATA)  ? r_tx_shift[0] : 1'b1;

    always_ff @(posedge clk) begin
        if (w_push)
            r_fifo[r_wr_ptr[PTR_W-2:0]] <= out_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_txd      <= 1'b1;
            r_tx_tail  <= 1'b0;
        end else begin
            r_txd     <= w_tx_line;
            r_tx_tail <= (r_tx_state == TX_STOP) && w_tx_last && !w_pop;
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_tx_shift <= r_fifo[r_rd_ptr[PTR_W-2:0]];
                r_tx_cnt   <= '0;
                r_tx_state <= TX_START;
            end else begin
                case (r_tx_state)
                    TX_IDLE: r_tx_cnt <= '0;
                    TX_START: begin
                        if (w_tx_last) begin
                            r_tx_cnt   <= '0;
                            r_tx_bit   <= '0;
                            r_tx_state <= TX_DATA;
                        end else begin
                            r_tx_cnt <= r_tx_cnt + 1'b1;
                        end
                    end
                    TX_DATA: begin
                        if (w_tx_last) begin
                            r_tx_cnt   <= '0;
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            r_tx_bit   <= r_tx_bit + 1'b1;
                            if (r_tx_bit == 3'd7)
                                r_tx_state <= TX_STOP;
                        end else begin
                            r_tx_cnt <= r_tx_cnt + 1'b1;
                        end
                    end
                    default: begin
                        if (w_tx_last) begin
                            r_tx_cnt   <= '0;
                            r_tx_state <= TX_IDLE;
                        end else begin
                            r_tx_cnt <= r_tx_cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    // Line output is registered, so busy is stretched by one cycle to cover the wire tail.
    assign uart_txd = r_txd;
    assign tx_busy  = !w_empty || (r_tx_state != TX_IDLE) || r_tx_tail;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_error    <= 1'b0;
            tx_overflow <= 1'b0;
        end else begin
            if (w_rx_err_set)
                rx_error <= 1'b1;
            else if (err_clr)
                rx_error <= 1'b0;
            if (w_ovf_set)
                tx_overflow <= 1'b1;
            else if (err_clr)
                tx_overflow <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_io_bridge.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_io_bridge
// Brief  : Directed self-checking bench for uart_io_bridge (8 clocks per bit).
// Rev    : 1.0  initial release
// ============================================================================
module tb_uart_io_bridge;
    localparam int CPB  = 8;
    localparam int TOUT = 320;

    logic       clk = 1'b0;
    logic       rst, uart_rxd, out_we, err_clr;
    logic [7:0] out_data;
    logic       uart_txd, mem_we, tx_busy, tx_overflow, rx_error;
    logic [3:0] mem_addr;
    logic [7:0] mem_data;

    int         n_vec = 0;
    int         n_bad = 0;
    int         we_count = 0;
    int         we_base;
    logic [3:0] last_addr = '0;
    logic [7:0] last_data = '0;

    logic [7:0] fb [5];
    int         fg [5];
    logic       fs [5];
    logic       fp [5];
    logic [7:0] one_b;
    int         one_g;
    logic       one_s, one_p;
    int         w;

    always #5 clk = ~clk;

    uart_io_bridge #(
        .CLKS_PER_BIT   (CPB),
        .ADDR_W         (4),
        .FIFO_DEPTH     (4),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .uart_rxd    (uart_rxd),
        .uart_txd    (uart_txd),
        .out_data    (out_data),
        .out_we      (out_we),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_we      (mem_we),
        .tx_busy     (tx_busy),
        .tx_overflow (tx_overflow),
        .rx_error    (rx_error),
        .err_clr     (err_clr)
    );

    always @(negedge clk) begin
        if (!rst && mem_we) begin
            we_count  = we_count + 1;
            last_addr = mem_addr;
            last_data = mem_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        uart_rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rxd = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
    endtask

    // Waits (bounded) for a start bit, then samples every bit at mid-period.
    task automatic get_frame(output logic [7:0] b, output int gap,
                             output logic start_ok, output logic stop_ok);
        gap = 0;
        while (uart_txd !== 1'b0 && gap < 400) begin
            @(negedge clk);
            gap++;
        end
        repeat (CPB/2) @(negedge clk);
        start_ok = (uart_txd === 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = uart_txd;
        end
        repeat (CPB) @(negedge clk);
        stop_ok = (uart_txd === 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; uart_rxd = 1'b1; out_we = 1'b0; out_data = 8'h00; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_txd", uart_txd, 1);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_data", mem_data, 0);
        chk("rst_tx_busy", tx_busy, 0);
        chk("rst_tx_ovf", tx_overflow, 0);
        chk("rst_rx_err", rx_error, 0);

        // Clean frame
        send_byte(8'hA5, 1'b1); send_byte(8'h03, 1'b1); send_byte(8'h7E, 1'b1);
        repeat (4) @(negedge clk);
        chk("f1_we_count", we_count, 1);
        chk("f1_addr", last_addr, 4'h3);
        chk("f1_data", last_data, 8'h7E);
        chk("f1_rx_err", rx_error, 0);

        // Junk, sync, bad address, then a byte that must be ignored
        send_byte(8'h12, 1'b1); send_byte(8'hA5, 1'b1);
        send_byte(8'h1F, 1'b1); send_byte(8'h55, 1'b1);
        repeat (4) @(negedge clk);
        chk("badaddr_rx_err", rx_error, 1);
        chk("badaddr_no_we", we_count, 1);
        chk("hold_addr", mem_addr, 4'h3);
        chk("hold_data", mem_data, 8'h7E);
        pulse_clr();
        chk("clr_rx_err", rx_error, 0);

        // Frame timeout between address and data
        send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1);
        repeat (100) @(negedge clk);
        chk("no_early_timeout", rx_error, 0);
        repeat (300) @(negedge clk);
        chk("timeout_rx_err", rx_error, 1);
        chk("timeout_no_we", we_count, 1);
        pulse_clr();
        chk("timeout_clr", rx_error, 0);
        send_byte(8'hA5, 1'b1); send_byte(8'h02, 1'b1); send_byte(8'h44, 1'b1);
        repeat (4) @(negedge clk);
        chk("f2_we_count", we_count, 2);
        chk("f2_addr", last_addr, 4'h2);
        chk("f2_data", last_data, 8'h44);
        chk("f2_rx_err", rx_error, 0);

        // Framing error: the discarded A5 must not open a frame
        send_byte(8'hA5, 1'b0);
        repeat (4) @(negedge clk);
        chk("frame_err", rx_error, 1);
        pulse_clr();
        chk("frame_err_clr", rx_error, 0);
        send_byte(8'h03, 1'b1); send_byte(8'h7E, 1'b1);
        repeat (4) @(negedge clk);
        chk("frame_err_no_we", we_count, 2);
        chk("frame_err_after", rx_error, 0);

        // TX: a leading byte keeps the engine busy so the 4-entry FIFO fills from empty
        we_base = we_count;
        out_data = 8'hC3; out_we = 1'b1;
        @(negedge clk);
        out_we = 1'b0;
        fork
            begin
                for (int k = 0; k < 5; k++) get_frame(fb[k], fg[k], fs[k], fp[k]);
            end
            begin
                repeat (4) @(negedge clk);
                for (int k = 1; k <= 6; k++) begin
                    out_data = 8'(k); out_we = 1'b1;
                    @(negedge clk);
                end
                out_we = 1'b0;
            end
        join
        chk("tx_byte0", fb[0], 8'hC3);
        chk("tx_byte1", fb[1], 8'h01);
        chk("tx_byte2", fb[2], 8'h02);
        chk("tx_byte3", fb[3], 8'h03);
        chk("tx_byte4", fb[4], 8'h04);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("tx_start%0d", k), fs[k], 1);
            chk($sformatf("tx_stop%0d", k), fp[k], 1);
        end
        for (int k = 1; k < 5; k++) chk($sformatf("tx_gap%0d", k), fg[k], CPB/2);
        chk("tx_ovf", tx_overflow, 1);
        w = 0;
        while (tx_busy && w < 10) begin
            @(negedge clk);
            w++;
        end
        chk("tx_busy_fall", tx_busy, 0);
        chk("tx_line_idle", uart_txd, 1);
        chk("tx_no_rx_side", we_count, we_base);
        pulse_clr();
        chk("tx_ovf_clr", tx_overflow, 0);

        // Reset in the middle of a byte (bit 2 of 5A is low)
        out_data = 8'h5A; out_we = 1'b1;
        @(negedge clk);
        out_we = 1'b0;
        repeat (29) @(negedge clk);
        chk("tx_mid_low", uart_txd, 0);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_txd", uart_txd, 1);
        chk("rst_async_busy", tx_busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_busy", tx_busy, 0);
        chk("post_rst_txd", uart_txd, 1);

        // Latency from an idle engine, then a complete frame
        out_data = 8'h3C; out_we = 1'b1;
        @(negedge clk);
        out_we = 1'b0;
        chk("lat_c1_busy", tx_busy, 1);
        chk("lat_c1_txd", uart_txd, 1);
        @(negedge clk);
        chk("lat_c2_txd", uart_txd, 1);
        @(negedge clk);
        chk("lat_c3_txd", uart_txd, 0);
        get_frame(one_b, one_g, one_s, one_p);
        chk("post_rst_byte", one_b, 8'h3C);
        chk("post_rst_start", one_s, 1);
        chk("post_rst_stop", one_p, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_io_bridge.md
# uart_io_bridge

Parametrised UART bridge between a host PC and the 8-bit computer. It contains its own RX and TX bit engines, so it has no dependency on other UART modules. On the receive side, it parses framed memory-write commands (sync, address, data) and emits one-cycle write strobes to program RAM. On the transmit side, it buffers output-register writes in a FIFO so back-to-back OI pulses are not lost while a byte is on the wire.

## Interface
- CLKS_PER_BIT, 5208, clock cycles per UART bit (50 MHz / 9600); must be ≥ 4.
- ADDR_W, 4, memory address width, 1..8.
- FIFO_DEPTH, 8, TX FIFO entries, power of two, ≥ 2.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_CYCLES, 10*5208*4, maximum idle cycles between bytes of one frame.

Ports:
- clk  in  1  system clock (CLOCK_50)
- rst  in  1  asynchronous, active-high reset
- uart_rxd  in  1  serial input from host; asynchronous, idle high
- uart_txd  out  1  serial output to host; idle high
- out_data  in  8  output-register value to transmit
- out_we  in  1  OI strobe; pushes out_data into the TX FIFO
- mem_addr  out  ADDR_W  write address
- mem_data  out  8  write data
- mem_we  out  1  one-cycle write strobe
- tx_busy  out  1  FIFO non-empty or TX engine active
- tx_overflow  out  1  sticky: a push was dropped because the FIFO was full
- rx_error  out  1  sticky: framing error, bad address byte, or frame timeout
- err_clr  in  1  synchronous clear of both sticky flags

## Operation
- **RX engine:**
  - uart_rxd passes through a 2-FF synchroniser (reset value 1).
  - IDLE → START on a falling edge. In START, sample at CLKS_PER_BIT/2. If the sample is low, go to DATA; otherwise return to IDLE (glitch).
  - Take 8 DATA samples, one every CLKS_PER_BIT cycles, LSB first.
  - Sample STOP. If STOP=1, assert a one-cycle byte_valid. If STOP=0, set rx_error and discard the byte. Then return to IDLE.
- **Frame parser:**
  - States: WAIT_SYNC, WAIT_ADDR, WAIT_DATA.
  - WAIT_SYNC: a byte equal to SYNC_BYTE advances to WAIT_ADDR; any other byte is ignored silently.
  - WAIT_ADDR: if bits [7:ADDR_W] are nonzero, set rx_error and go to WAIT_SYNC. Otherwise latch the address and advance.
  - WAIT_DATA: latch the data, pulse mem_we, go to WAIT_SYNC.
  - An idle counter resets on each byte_valid. If it reaches TIMEOUT_CYCLES in WAIT_ADDR or WAIT_DATA, set rx_error and go to WAIT_SYNC.
  - A framing-error byte aborts the frame (go to WAIT_SYNC).
- **TX FIFO:**
  - Circular buffer with pointers one bit wider than log2(FIFO_DEPTH); the pointers wrap naturally.
  - Full when the low bits are equal and the MSBs differ. Empty when the pointers are equal.
  - out_we while full drops the byte and sets tx_overflow.
  - A push and a pop in the same cycle while full: the pop happens and the push is accepted (count unchanged, no overflow).
- **TX engine:**
  - States: IDLE, START, DATA×8 (LSB first), STOP; each bit is held for CLKS_PER_BIT cycles.
  - In IDLE with the FIFO non-empty, pop and load the shifter.
- **Sticky flags:** err_clr clears both. If a set and err_clr occur in the same cycle, set wins.

## Timing
- **Reset values:**
  - uart_txd=1, mem_we=0, mem_addr=0, mem_data=0, tx_busy=0, tx_overflow=0, rx_error=0.
  - FIFO empty, all FSMs idle, parser in WAIT_SYNC.
  - Reset mid-byte aborts immediately: uart_txd returns to 1 asynchronously, and no partial frame survives.
- **RX latency:** byte_valid rises 1 cycle after the stop-bit sample. mem_we rises on the cycle after byte_valid of the data byte. mem_addr/mem_data are valid in that same cycle and hold until the next write.
- **TX latency:** from out_we into an empty FIFO with the engine idle:
  - cycle +1: FIFO non-empty, tx_busy=1
  - cycle +2: pop
  - cycle +3: uart_txd drops (start bit)
- **Frame length:** each byte occupies 10*CLKS_PER_BIT cycles on the wire. Back-to-back FIFO bytes follow with zero idle cycles between the stop bit and the next start bit.
- **tx_busy timing:** tx_busy falls on the cycle after the final stop-bit period ends with the FIFO empty.

## Test plan
All scenarios use CLKS_PER_BIT=8, ADDR_W=4, FIFO_DEPTH=4.
- Send A5, 03, 7E as clean frames → exactly one mem_we pulse with mem_addr=3 and mem_data=7E; rx_error=0.
- Send 12, A5, 1F, 55 → 12 is ignored. After A5, the address byte 1F has nonzero upper bits, so rx_error=1 and no mem_we occurs. The parser is back in WAIT_SYNC, so 55 is ignored.
- Send A5, 02, then stay idle for TIMEOUT_CYCLES → rx_error=1. Then send A5, 02, 44 → mem_we with address 2 and data 44.
- Send a byte with its stop bit forced to 0 → rx_error=1 and no byte accepted. Then pulse err_clr → rx_error=0.
- Apply out_we on 6 consecutive cycles with data 01..06 → bytes 01..04 are accepted and 05 and 06 are dropped (tx_overflow=1). The line shows 01,02,03,04 back to back, LSB first, each with a correct start and stop bit; tx_busy then falls.
- Assert rst halfway through a TX byte → uart_txd=1 immediately, FIFO empty, tx_busy=0. The first out_we after release transmits a complete frame.
